// File: rtl/vector_control_seq_if.sv
// Instruction handshake, memory/flush inputs and per-element control outputs of the sequencer.
// The master side offers instructions; the slave side (sequencer) drives ready, element and control signals.
interface vector_control_seq_if #(
   parameter int LANES = 4,
   parameter int IW    = $clog2(LANES)
);
   logic          instr_valid;
   logic          instr_ready;
   logic [1:0]    op;
   logic [6:0]    funct;
   logic [IW:0]   vlen;
   logic          mem_ack;
   logic          flush;
   logic          elem_valid;
   logic [IW-1:0] elem_idx;
   logic          elem_last;
   logic          reg_s_write;
   logic          reg_v_write;
   logic          alu_s_src;
   logic          alu_v_src;
   logic          mem_write;
   logic          mem_to_reg;
   logic          branch;
   logic          flags_we;
   logic [1:0]    alu_control;
   logic          done;
   logic          illegal;

   modport master (
      output instr_valid, op, funct, vlen, mem_ack, flush,
      input  instr_ready, elem_valid, elem_idx, elem_last, reg_s_write, reg_v_write,
             alu_s_src, alu_v_src, mem_write, mem_to_reg, branch, flags_we,
             alu_control, done, illegal
   );

   modport slave (
      input  instr_valid, op, funct, vlen, mem_ack, flush,
      output instr_ready, elem_valid, elem_idx, elem_last, reg_s_write, reg_v_write,
             alu_s_src, alu_v_src, mem_write, mem_to_reg, branch, flags_we,
             alu_control, done, illegal
   );
endinterface

// File: rtl/vector_control_seq.sv
// Vector instruction sequencer: one element per cycle (memory ops wait on mem_ack), DONE with the last element.
// Ready only in IDLE; flush aborts in-flight work next cycle and blocks acceptance in the same cycle.
module vector_control_seq #(
   parameter int LANES = 4,
   parameter int IW    = $clog2(LANES)
) (
   input  logic                clk,
   input  logic                rst_n,
   vector_control_seq_if.slave bus
);
   typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

   localparam logic [IW:0] LANES_W = (IW+1)'(LANES);

   state_t        state_q, state_d;
   logic [1:0]    op_q, op_d;
   logic [6:0]    funct_q, funct_d;
   logic [IW-1:0] cnt_q, cnt_d;
   logic [IW:0]   count_q, count_d;

   logic ready, accept, exec, in_scalar, is_scalar, is_mem, is_load, elem_done, last;

   // Ready is held low while reset is asserted so every output reads 0 during reset.
   assign ready     = (state_q == IDLE) && rst_n;
   assign accept    = ready && bus.instr_valid && !bus.flush;
   assign exec      = (state_q == EXEC);
   assign in_scalar = (bus.op == 2'b10) || (bus.funct[6:5] == 2'b00);
   assign is_scalar = (op_q == 2'b10) || (funct_q[6:5] == 2'b00);
   assign is_mem    = (op_q == 2'b01);
   assign is_load   = is_mem && funct_q[3];
   assign elem_done = exec && !bus.flush && (!is_mem || bus.mem_ack);
   assign last      = ({1'b0, cnt_q} == (count_q - {{IW{1'b0}}, 1'b1}));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         funct_q <= '0;
         cnt_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         funct_q <= funct_d;
         cnt_q   <= cnt_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      funct_d = funct_q;
      cnt_d   = cnt_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d    = bus.op;
               funct_d = bus.funct;
               cnt_d   = '0;
               if (in_scalar)
                  count_d = {{IW{1'b0}}, 1'b1};
               else if ((bus.vlen == '0) || (bus.vlen > LANES_W))
                  count_d = LANES_W;
               else
                  count_d = bus.vlen;
               if (bus.op != 2'b11)
                  state_d = EXEC;
            end
         end
         EXEC: begin
            if (bus.flush)
               state_d = IDLE;
            else if (elem_done) begin
               if (last)
                  state_d = IDLE;
               else
                  cnt_d = cnt_q + {{(IW-1){1'b0}}, 1'b1};
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.instr_ready = ready;
      bus.illegal     = accept && (bus.op == 2'b11);
      bus.elem_valid  = 1'b0;
      bus.elem_idx    = '0;
      bus.elem_last   = 1'b0;
      bus.reg_s_write = 1'b0;
      bus.reg_v_write = 1'b0;
      bus.alu_s_src   = 1'b0;
      bus.alu_v_src   = 1'b0;
      bus.mem_write   = 1'b0;
      bus.mem_to_reg  = 1'b0;
      bus.branch      = 1'b0;
      bus.flags_we    = 1'b0;
      bus.alu_control = 2'b00;
      bus.done        = 1'b0;
      if (exec) begin
         bus.elem_valid  = 1'b1;
         bus.elem_idx    = cnt_q;
         bus.elem_last   = last;
         bus.alu_control = funct_q[1:0];
         bus.done        = elem_done && last;
         case (op_q)
            2'b00: begin
               if (is_scalar) begin
                  bus.alu_s_src = funct_q[4];
                  if (funct_q[2:0] == 3'b101)
                     bus.flags_we = 1'b1;
                  else
                     bus.reg_s_write = 1'b1;
               end else begin
                  bus.reg_v_write = 1'b1;
                  bus.alu_v_src   = (funct_q[6:5] == 2'b11);
                  bus.alu_s_src   = 1'b1;
               end
            end
            2'b01: begin
               bus.alu_s_src = 1'b1;
               // Load write-back only fires on the accepted ack; stores hold mem_write while waiting.
               if (is_load) begin
                  bus.mem_to_reg  = elem_done;
                  bus.reg_s_write = elem_done && is_scalar;
                  bus.reg_v_write = elem_done && !is_scalar;
               end else begin
                  bus.mem_write = 1'b1;
               end
            end
            2'b10: begin
               bus.branch    = 1'b1;
               bus.alu_s_src = 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_vector_control_seq.sv
// Directed bench for vector_control_seq (LANES=4); expected output words are hand-computed per scenario.
module tb_vector_control_seq;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   vector_control_seq_if #(.LANES(4)) vif ();

   vector_control_seq #(.LANES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (vif.slave)
   );

   // Word layout: {ready, illegal, valid, idx[1:0], last, ctl[7:0], alu[1:0], done}
   // ctl = {reg_s_write, reg_v_write, alu_s_src, alu_v_src, mem_write, mem_to_reg, branch, flags_we}
   function automatic logic [16:0] pk(logic rdy, logic ill, logic vld, logic [1:0] idx, logic lst,
                                      logic [7:0] ctl, logic [1:0] alu, logic dn);
      return {rdy, ill, vld, idx, lst, ctl, alu, dn};
   endfunction

   function automatic logic [16:0] obs();
      return {vif.instr_ready, vif.illegal, vif.elem_valid, vif.elem_idx, vif.elem_last,
              vif.reg_s_write, vif.reg_v_write, vif.alu_s_src, vif.alu_v_src,
              vif.mem_write, vif.mem_to_reg, vif.branch, vif.flags_we, vif.alu_control, vif.done};
   endfunction

   localparam logic [16:0] IDLE_W = 17'h10000;

   task automatic send(input logic [1:0] op, input logic [6:0] funct, input logic [2:0] vlen);
      @(negedge clk);
      vif.instr_valid = 1'b1;
      vif.op = op;
      vif.funct = funct;
      vif.vlen = vlen;
      @(negedge clk);
      vif.instr_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      n_cmp++; if (obs() !== 17'h0) begin n_err++; $display("FAIL reset_hold got %h want %h", obs(), 17'h0); end
      @(negedge clk); rst_n = 1'b1; #1;
      n_cmp++; if (obs() !== IDLE_W) begin n_err++; $display("FAIL reset_release got %h want %h", obs(), IDLE_W); end
   endtask

   task automatic test_scalar_add();
      logic [16:0] e;
      send(2'b00, 7'b0000000, 3'd0);
      e = pk(0, 0, 1, 2'd0, 1, 8'b1000_0000, 2'b00, 1);
      n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL scalar_add got %h want %h", obs(), e); end
      @(negedge clk); #1;
      n_cmp++; if (obs() !== IDLE_W) begin n_err++; $display("FAIL scalar_add_ret got %h want %h", obs(), IDLE_W); end
   endtask

   task automatic test_vector_sub();
      logic [16:0] e;
      send(2'b00, 7'b1100001, 3'd0);
      for (int i = 0; i < 4; i++) begin
         e = pk(0, 0, 1, 2'(i), i == 3, 8'b0111_0000, 2'b01, i == 3);
         n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL vsub_idx%0d got %h want %h", i, obs(), e); end
         @(negedge clk); #1;
      end
      n_cmp++; if (obs() !== IDLE_W) begin n_err++; $display("FAIL vsub_ret got %h want %h", obs(), IDLE_W); end
   endtask

   task automatic test_vector_load();
      logic [16:0] e;
      logic        ack;
      logic        fin = 1'b0;
      int          exp_idx = 0;
      send(2'b01, 7'b0101000, 3'd2);
      for (int c = 0; c < 12 && !fin; c++) begin
         ack = (c % 3 == 2);
         vif.mem_ack = ack;
         #1;
         e = pk(0, 0, 1, 2'(exp_idx), exp_idx == 1, {1'b0, ack, 1'b1, 2'b00, ack, 2'b00}, 2'b00,
                ack && exp_idx == 1);
         n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL vload_c%0d got %h want %h", c, obs(), e); end
         if (ack) begin
            if (exp_idx == 1) fin = 1'b1;
            exp_idx++;
         end
         @(negedge clk); #1;
      end
      vif.mem_ack = 1'b0;
      n_cmp++; if (!fin) begin n_err++; $display("FAIL vload_timeout got %0b want 1", fin); end
      #1;
      n_cmp++; if (obs() !== IDLE_W) begin n_err++; $display("FAIL vload_ret got %h want %h", obs(), IDLE_W); end
   endtask

   task automatic test_store_branch();
      logic [16:0] e;
      send(2'b01, 7'b0000000, 3'd1);
      e = pk(0, 0, 1, 2'd0, 1, 8'b0010_1000, 2'b00, 0);
      n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL store_wait got %h want %h", obs(), e); end
      @(negedge clk); vif.mem_ack = 1'b1; #1;
      e = pk(0, 0, 1, 2'd0, 1, 8'b0010_1000, 2'b00, 1);
      n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL store_ack got %h want %h", obs(), e); end
      @(negedge clk); vif.mem_ack = 1'b0; #1;
      n_cmp++; if (obs() !== IDLE_W) begin n_err++; $display("FAIL store_ret got %h want %h", obs(), IDLE_W); end
      send(2'b10, 7'b1100010, 3'd3);
      e = pk(0, 0, 1, 2'd0, 1, 8'b0010_0010, 2'b10, 1);
      n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL branch got %h want %h", obs(), e); end
      @(negedge clk); #1;
      n_cmp++; if (obs() !== IDLE_W) begin n_err++; $display("FAIL branch_ret got %h want %h", obs(), IDLE_W); end
   endtask

   task automatic test_compare();
      logic [16:0] e;
      send(2'b00, 7'b0000101, 3'd0);
      e = pk(0, 0, 1, 2'd0, 1, 8'b0000_0001, 2'b01, 1);
      n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL compare got %h want %h", obs(), e); end
      @(negedge clk); #1;
   endtask

   task automatic test_illegal();
      logic [16:0] e;
      @(negedge clk);
      vif.instr_valid = 1'b1; vif.op = 2'b11; vif.funct = 7'b0000000; vif.vlen = 3'd0;
      #1;
      e = pk(1, 1, 0, 2'd0, 0, 8'b0, 2'b00, 0);
      n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL illegal_pulse got %h want %h", obs(), e); end
      @(negedge clk); vif.instr_valid = 1'b0; #1;
      for (int i = 0; i < 2; i++) begin
         n_cmp++; if (obs() !== IDLE_W) begin n_err++; $display("FAIL illegal_after%0d got %h want %h", i, obs(), IDLE_W); end
         @(negedge clk); #1;
      end
   endtask

   task automatic test_flush();
      logic [16:0] e;
      send(2'b01, 7'b0101000, 3'd4);
      vif.mem_ack = 1'b1; #1;
      e = pk(0, 0, 1, 2'd0, 0, 8'b0110_0100, 2'b00, 0);
      n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL flush_idx0 got %h want %h", obs(), e); end
      @(negedge clk); vif.flush = 1'b1; #1;
      e = pk(0, 0, 1, 2'd1, 0, 8'b0010_0000, 2'b00, 0);
      n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL flush_idx1 got %h want %h", obs(), e); end
      @(negedge clk); vif.flush = 1'b0; vif.mem_ack = 1'b0; #1;
      n_cmp++; if (obs() !== IDLE_W) begin n_err++; $display("FAIL flush_ret got %h want %h", obs(), IDLE_W); end
      // Flush in IDLE must also block an offered instruction.
      @(negedge clk);
      vif.instr_valid = 1'b1; vif.op = 2'b00; vif.funct = 7'b0000000; vif.flush = 1'b1;
      @(negedge clk); vif.instr_valid = 1'b0; vif.flush = 1'b0; #1;
      n_cmp++; if (obs() !== IDLE_W) begin n_err++; $display("FAIL flush_block got %h want %h", obs(), IDLE_W); end
   endtask

   task automatic test_vlen_clamp();
      logic [16:0] e;
      send(2'b00, 7'b0100000, 3'd7);
      for (int i = 0; i < 4; i++) begin
         e = pk(0, 0, 1, 2'(i), i == 3, 8'b0110_0000, 2'b00, i == 3);
         n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL clamp_idx%0d got %h want %h", i, obs(), e); end
         @(negedge clk); #1;
      end
      n_cmp++; if (obs() !== IDLE_W) begin n_err++; $display("FAIL clamp_ret got %h want %h", obs(), IDLE_W); end
   endtask

   task automatic test_reset_mid();
      logic [16:0] e;
      send(2'b00, 7'b1100001, 3'd0);
      @(negedge clk); #1;
      e = pk(0, 0, 1, 2'd1, 0, 8'b0111_0000, 2'b01, 0);
      n_cmp++; if (obs() !== e) begin n_err++; $display("FAIL rstmid_pre got %h want %h", obs(), e); end
      rst_n = 1'b0; #1;
      n_cmp++; if (obs() !== 17'h0) begin n_err++; $display("FAIL rstmid_zero got %h want %h", obs(), 17'h0); end
      @(negedge clk); rst_n = 1'b1; #1;
      n_cmp++; if (obs() !== IDLE_W) begin n_err++; $display("FAIL rstmid_ret got %h want %h", obs(), IDLE_W); end
      @(negedge clk); #1;
      n_cmp++; if (obs() !== IDLE_W) begin n_err++; $display("FAIL rstmid_stay got %h want %h", obs(), IDLE_W); end
   endtask

   initial begin
      vif.instr_valid = 1'b0;
      vif.op          = 2'b00;
      vif.funct       = 7'b0;
      vif.vlen        = 3'd0;
      vif.mem_ack     = 1'b0;
      vif.flush       = 1'b0;
      test_reset();
      test_scalar_add();
      test_vector_sub();
      test_vector_load();
      test_store_branch();
      test_compare();
      test_illegal();
      test_flush();
      test_vlen_clamp();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/vector_control_seq.md
VECTOR_CONTROL_SEQ -- requirements
Module: vector_control_seq

Interface
REQ-001 SHALL have parameter LANES, default 4, vector element count (power of two, 2..16).
REQ-002 SHALL have parameter IW = $clog2(LANES), default 2, element index width.
REQ-003 SHALL have ports CLK in 1, single clock; RST_N in 1, reset, asynchronous, active-low.
REQ-004 SHALL have ports INSTR_VALID in 1, instruction offered; INSTR_READY out 1, sequencer can accept.
REQ-005 SHALL have ports OP in 2, opcode class; FUNCT in 7, function field; VLEN in IW+1, requested element count.
REQ-006 SHALL have ports MEM_ACK in 1, memory completed current element; FLUSH in 1, synchronous abort.
REQ-007 SHALL have ports ELEM_VALID out 1, element issuing; ELEM_IDX out IW, element index; ELEM_LAST out 1, final element.
REQ-008 SHALL have ports REG_S_WRITE, REG_V_WRITE, ALU_S_SRC, ALU_V_SRC, MEM_WRITE, MEM_TO_REG, BRANCH, FLAGS_WE, each out 1, per-element controls.
REQ-009 SHALL have ports ALU_CONTROL out 2, ALU op; DONE out 1, instruction retired; ILLEGAL out 1, OP=11 rejected.

Function
REQ-010 SHALL implement states IDLE, EXEC, with INSTR_READY=1 only in IDLE.
REQ-011 SHALL accept on INSTR_VALID&&INSTR_READY, latching OP, FUNCT, VLEN, and clearing element counter to 0.
REQ-012 SHALL on OP=11 acceptance pulse ILLEGAL one cycle, stay IDLE, issue no elements.
REQ-013 SHALL classify accepted instruction as scalar if OP=10 or FUNCT[6:5]=00, else vector.
REQ-014 SHALL set element count to 1 for scalar; for vector to VLEN, with VLEN=0 or VLEN>LANES clamped to LANES.
REQ-015 SHALL in EXEC drive ELEM_VALID=1, ELEM_IDX=counter, ELEM_LAST=1 when counter = count-1.
REQ-016 SHALL complete an element every cycle for OP=00/10, and only in cycles with MEM_ACK=1 for OP=01 (outputs held while waiting).
REQ-017 SHALL increment counter on element completion; on completion of last element pulse DONE same cycle and enter IDLE next cycle.
REQ-018 SHALL drive ALU_CONTROL=FUNCT[1:0] of latched instruction while ELEM_VALID, else 00.
REQ-019 SHALL decode OP=00 scalar: REG_S_WRITE=1, ALU_S_SRC=FUNCT[4]; except FUNCT[2:0]=101 (compare): REG_S_WRITE=0, FLAGS_WE=1.
REQ-020 SHALL decode OP=00 vector: REG_V_WRITE=1, ALU_V_SRC=(FUNCT[6:5]=11), ALU_S_SRC=1.
REQ-021 SHALL decode OP=01: ALU_S_SRC=1; FUNCT[3]=1 load: MEM_TO_REG=1 and REG_S_WRITE (scalar) or REG_V_WRITE (vector); FUNCT[3]=0 store: MEM_WRITE=1.
REQ-022 SHALL assert REG_V_WRITE, REG_S_WRITE, MEM_TO_REG for loads only in the MEM_ACK cycle; MEM_WRITE held through wait.
REQ-023 SHALL decode OP=10: BRANCH=1, ALU_S_SRC=1, single element.
REQ-024 SHALL force all control outputs, ELEM_VALID, ELEM_LAST to 0 when not in EXEC.
REQ-025 SHALL on FLUSH=1 return to IDLE next cycle without DONE; FLUSH has priority over MEM_ACK and acceptance in the same cycle.
REQ-026 SHALL ignore MEM_ACK in IDLE and for non-memory instructions.

Reset
REQ-027 SHALL on RST_N=0 asynchronously enter IDLE, counter=0, latched fields=0, all outputs 0 except INSTR_READY=1 after reset release.
REQ-028 SHALL abandon any in-flight instruction on reset mid-EXEC, with no DONE.

Verification
REQ-029 Scalar ADD OP=00 FUNCT=0000000 -> one cycle ELEM_VALID, ELEM_IDX=0, ELEM_LAST=1, REG_S_WRITE=1, ALU_CONTROL=00, DONE=1, INSTR_READY=1 next cycle.
REQ-030 Vector-vector SUB FUNCT=1100001, VLEN=0, LANES=4 -> ELEM_IDX 0,1,2,3 consecutive, REG_V_WRITE=1, ALU_V_SRC=1, ELEM_LAST and DONE on idx 3.
REQ-031 Vector load OP=01 FUNCT=0101000, VLEN=2, MEM_ACK high only every third cycle -> idx 0 held until ack, REG_V_WRITE only on ack cycles, DONE on second ack.
REQ-032 Compare FUNCT=0000101 -> REG_S_WRITE=0, FLAGS_WE=1; OP=11 -> ILLEGAL pulse, no ELEM_VALID.
REQ-033 FLUSH at idx 1 of 4-element op with simultaneous MEM_ACK -> IDLE next cycle, no DONE; VLEN=7 with LANES=4 -> 4 elements.
REQ-034 RST_N low mid-vector op -> all outputs 0 immediately, INSTR_READY=1 after release.
